// File: rtl/rule_match_collector_if.sv
// Stream bundle between the rule check stage, the match collector and the rule-reporting consumer.
// The collector takes the slave view. The upstream/consumer side takes the master view.
interface rule_match_collector_if #(
  parameter int RULE_AWIDTH = 13
);
  logic [RULE_AWIDTH-1:0] in_rule_data;
  logic                   in_rule_valid;
  logic                   in_last;
  logic [RULE_AWIDTH-1:0] out_rule_data;
  logic                   out_rule_last;
  logic                   out_rule_valid;
  logic                   out_rule_ready;

  modport master (
    output in_rule_data,
    output in_rule_valid,
    output in_last,
    input  out_rule_data,
    input  out_rule_last,
    input  out_rule_valid,
    output out_rule_ready
  );

  modport slave (
    input  in_rule_data,
    input  in_rule_valid,
    input  in_last,
    output out_rule_data,
    output out_rule_last,
    output out_rule_valid,
    input  out_rule_ready
  );
endinterface

// File: rtl/rule_match_collector.sv
// Per-packet rule ID dedup feeding a show-ahead FIFO. Input to out_rule_valid takes 2 cycles.
// Upstream cannot be stalled: when the FIFO is short of space, rules are dropped and counted, and the last slot is kept for terminators.
module rule_match_collector #(
  parameter int RULE_AWIDTH = 13,
  parameter int FIFO_DEPTH  = 32,
  parameter int DEDUP_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  rule_match_collector_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   rule_cnt,
  output logic [31:0]                   dup_cnt,
  output logic [31:0]                   drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RULE_AWIDTH-1:0] id;
    logic                   last;
  } entry_t;

  logic [RULE_AWIDTH-1:0] r_s1_data;
  logic                   r_s1_vld;
  logic                   r_s1_last;

  logic [RULE_AWIDTH-1:0] r_tbl [DEDUP_DEPTH];
  logic [DEDUP_DEPTH-1:0] r_tbl_vld;

  entry_t                 r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [31:0]            r_rule_cnt;
  logic [31:0]            r_dup_cnt;
  logic [31:0]            r_drop_cnt;

  logic                   w_hit;
  logic                   w_rule_new;
  logic                   w_room;
  logic                   w_full;
  logic                   w_push_rule;
  logic                   w_push_term;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_dup;
  logic                   w_pop;
  logic                   w_out_vld;
  entry_t                 w_push_ent;
  entry_t                 w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_data <= bus.in_rule_data;
      r_s1_vld  <= bus.in_rule_valid && (bus.in_rule_data != '0);
      r_s1_last <= bus.in_last;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEDUP_DEPTH; i++) begin
      if (r_tbl_vld[i] && (r_tbl[i] == r_s1_data)) w_hit = 1'b1;
    end
  end

  // Rules may only take the FIFO up to DEPTH-1; the final slot is held back for a terminator.
  assign w_out_vld   = (r_count != '0);
  assign w_pop       = w_out_vld && bus.out_rule_ready;
  assign w_room      = (r_count < CW'(FIFO_DEPTH - 1));
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_rule_new  = r_s1_vld && !w_hit;
  assign w_dup       = r_s1_vld && w_hit;
  assign w_push_rule = w_rule_new && w_room;
  assign w_drop      = w_rule_new && !w_room;
  assign w_push_term = r_s1_last && !w_push_rule && (!w_full || w_pop);
  assign w_push      = w_push_rule || w_push_term;

  always_comb begin
    w_push_ent.id   = '0;
    w_push_ent.last = 1'b1;
    if (w_push_rule) begin
      w_push_ent.id   = r_s1_data;
      w_push_ent.last = r_s1_last;
    end
  end

  // The packet boundary wipes the table on the same edge, so the next packet starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tbl_vld <= '0;
      for (int i = 0; i < DEDUP_DEPTH; i++) r_tbl[i] <= '0;
    end else if (r_s1_last) begin
      r_tbl_vld <= '0;
    end else if (w_push_rule) begin
      r_tbl_vld <= {r_tbl_vld[DEDUP_DEPTH-2:0], 1'b1};
      r_tbl[0]  <= r_s1_data;
      for (int i = 1; i < DEDUP_DEPTH; i++) r_tbl[i] <= r_tbl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rule_cnt <= '0;
      r_dup_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_push_rule) r_rule_cnt <= r_rule_cnt + 32'd1;
      if (w_dup)       r_dup_cnt  <= r_dup_cnt + 32'd1;
      if (w_drop)      r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign w_head             = r_mem[r_rd_ptr];
  assign bus.out_rule_valid = w_out_vld;
  assign bus.out_rule_data  = w_out_vld ? w_head.id : '0;
  assign bus.out_rule_last  = w_out_vld ? w_head.last : 1'b0;

  assign fifo_count = r_count;
  assign rule_cnt   = r_rule_cnt;
  assign dup_cnt    = r_dup_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule
